// File: rtl/etroc1_rx_decoder.sv
// ETROC1 readout frame decoder: finds HEADER / data / TRAILER frames in the
// deserialized word stream and queues tagged hits in a first-word-fall-through FIFO.
module etroc1_rx_decoder #(
    parameter logic [29:0] HEADER     = 30'h2AAA5555,
    parameter logic [29:0] TRAILER    = 30'h15553AAA,
    parameter int          FIFO_DEPTH = 32,
    parameter int          TIMEOUT    = 1023,
    parameter bit          DROP_EMPTY = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [29:0] din,
    input  logic        din_valid,
    input  logic [15:0] roi,
    input  logic        hit_ready,
    output logic        hit_valid,
    output logic [3:0]  hit_pixel,
    output logic [29:0] hit_data,
    output logic [11:0] hit_evt,
    output logic        event_done,
    output logic        frame_err,
    output logic [15:0] err_count,
    output logic        overflow,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_TRAIL} state_t;

    typedef struct packed {
        logic [3:0]  pix;
        logic [29:0] data;
        logic [11:0] evt;
    } hit_t;

    function automatic logic [3:0] lowest_set(input logic [15:0] m);
        lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) lowest_set = i[3:0];
    endfunction

    logic [29:0]   din_q;
    logic          vld_q;
    state_t        state_q, state_d;
    logic [15:0]   pend_q, pend_d;          // pixels of the current frame still awaiting a word
    logic [11:0]   evt_cnt_q, evt_cnt_d;
    logic [11:0]   cur_evt_q, cur_evt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          push_q, push_d;
    hit_t          push_ent_q, push_ent_d;
    logic          done_q, done_d;
    logic          ferr_q, ferr_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic          ovf_q;
    logic          hdr;
    logic [3:0]    pix;

    hit_t          mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic          full, do_pop, do_push;
    hit_t          head;

    assign pix = lowest_set(pend_q);

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        evt_cnt_d  = evt_cnt_q;
        cur_evt_d  = cur_evt_q;
        tmo_d      = tmo_q;
        push_d     = 1'b0;
        push_ent_d = '{pix: pix, data: din_q, evt: cur_evt_q};
        done_d     = 1'b0;
        ferr_d     = 1'b0;
        hdr        = 1'b0;

        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (vld_q && din_q == HEADER) hdr = 1'b1;
            end
            S_DATA, S_TRAIL: begin
                if (vld_q) begin
                    tmo_d = '0;
                    if (state_q == S_TRAIL) begin
                        // any trailer-slot word ends the frame, HEADER included
                        if (din_q == TRAILER) done_d = 1'b1;
                        else                  ferr_d = 1'b1;
                        state_d = S_IDLE;
                    end else if (din_q == HEADER) begin
                        ferr_d = 1'b1;
                        hdr    = 1'b1;
                    end else begin
                        push_d = !(DROP_EMPTY && din_q == 30'h0);
                        pend_d = pend_q & ~(16'd1 << pix);
                        if (pend_d == 16'h0) state_d = S_TRAIL;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    ferr_d  = 1'b1;
                    tmo_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (hdr) begin
            pend_d    = roi;
            cur_evt_d = evt_cnt_q;
            evt_cnt_d = evt_cnt_q + 12'd1;
            tmo_d     = '0;
            state_d   = (roi == 16'h0) ? S_TRAIL : S_DATA;
        end

        err_cnt_d = err_cnt_q;
        if (ferr_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    assign full    = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    assign do_pop  = hit_valid && hit_ready;
    assign do_push = push_q && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            din_q      <= '0;
            vld_q      <= 1'b0;
            state_q    <= S_IDLE;
            pend_q     <= '0;
            evt_cnt_q  <= '0;
            cur_evt_q  <= '0;
            tmo_q      <= '0;
            push_q     <= 1'b0;
            push_ent_q <= '0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
        end else begin
            din_q      <= din;
            vld_q      <= din_valid;
            state_q    <= state_d;
            pend_q     <= pend_d;
            evt_cnt_q  <= evt_cnt_d;
            cur_evt_q  <= cur_evt_d;
            tmo_q      <= tmo_d;
            push_q     <= push_d;
            push_ent_q <= push_ent_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
            err_cnt_q  <= err_cnt_d;
            if (push_q && full && !do_pop) ovf_q <= 1'b1;
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // storage needs no reset; the read side is masked while empty
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= push_ent_q;
    end

    assign head       = mem_q[rptr_q];
    assign hit_valid  = (cnt_q != '0);
    assign hit_pixel  = hit_valid ? head.pix  : 4'h0;
    assign hit_data   = hit_valid ? head.data : 30'h0;
    assign hit_evt    = hit_valid ? head.evt  : 12'h0;
    assign event_done = done_q;
    assign frame_err  = ferr_q;
    assign err_count  = err_cnt_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_etroc1_rx_decoder.sv
// Randomized frame-level bench for etroc1_rx_decoder with a hit scoreboard.
module tb_etroc1_rx_decoder;

    localparam logic [29:0] HEADER  = 30'h2AAA5555;
    localparam logic [29:0] TRAILER = 30'h15553AAA;
    localparam int          TIMEOUT = 1023;

    logic        clock = 1'b0;
    logic        reset;
    logic [29:0] din;
    logic        din_valid;
    logic [15:0] roi;
    logic        hit_ready;
    logic        hit_valid;
    logic [3:0]  hit_pixel;
    logic [29:0] hit_data;
    logic [11:0] hit_evt;
    logic        event_done, frame_err, overflow, busy;
    logic [15:0] err_count;

    etroc1_rx_decoder dut (
        .clock(clock), .reset(reset), .din(din), .din_valid(din_valid), .roi(roi),
        .hit_ready(hit_ready), .hit_valid(hit_valid), .hit_pixel(hit_pixel),
        .hit_data(hit_data), .hit_evt(hit_evt), .event_done(event_done),
        .frame_err(frame_err), .err_count(err_count), .overflow(overflow), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_fail = 0;
    int done_seen = 0, ferr_seen = 0, n_pop = 0;
    int exp_done = 0, exp_err = 0, m_evt = 0;
    bit rand_rdy = 1'b0;
    logic [45:0] exp_q[$];
    logic [29:0] dq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (event_done) done_seen++;
        if (frame_err)  ferr_seen++;
        if (hit_valid && hit_ready) begin
            n_pop++;
            if (exp_q.size() == 0) chk("hit_unexpected", 64'd1, 64'd0);
            else chk("hit", {18'd0, hit_pixel, hit_data, hit_evt}, {18'd0, exp_q.pop_front()});
        end
    end

    task automatic cyc();
        @(posedge clock); #1;
        if (rand_rdy) hit_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [29:0] w, input bit gaps);
        din = w; din_valid = 1'b1;
        cyc();
        din_valid = 1'b0; din = 30'($urandom);
        if (gaps) repeat ($urandom_range(0, 2)) cyc();
    endtask

    function automatic logic [29:0] rnd_word(input bit allow_zero);
        logic [29:0] w;
        w = (allow_zero && $urandom_range(0, 3) == 0) ? 30'h0 : 30'($urandom);
        if (w == HEADER || w == TRAILER || (!allow_zero && w == 30'h0)) w = 30'h1;
        return w;
    endfunction

    // term: 0 good trailer, 1 bad trailer, 2 truncated (next header restarts)
    task automatic run_frame(input logic [15:0] r, input int n, input int term, input bit gaps);
        int evt, k;
        roi = r;
        send_word(HEADER, gaps);
        evt = m_evt;
        m_evt = (m_evt + 1) % 4096;
        k = 0;
        for (int j = 0; j < n; j++) begin
            while (!r[k]) k++;
            if (dq[j] != 30'h0) exp_q.push_back({k[3:0], dq[j], evt[11:0]});
            send_word(dq[j], gaps);
            k++;
        end
        case (term)
            0: begin send_word(TRAILER, gaps); exp_done++; end
            1: begin send_word(30'h3FFFFFFF, gaps); exp_err++; end
            default: exp_err++;
        endcase
    endtask

    task automatic fill_dq(input int n, input bit allow_zero);
        dq.delete();
        for (int j = 0; j < n; j++) dq.push_back(rnd_word(allow_zero));
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) cyc();
        repeat (4) cyc();
        chk({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_counts(input string tag, input int bd, input int bf);
        chk({tag, "_done"}, 64'(done_seen - bd), 64'(exp_done));
        chk({tag, "_ferr"}, 64'(ferr_seen - bf), 64'(exp_err));
        chk({tag, "_errcnt"}, 64'(err_count), 64'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pc, term, n, prev_term, bd, bf;
        logic [15:0] r;
        reset = 1'b1; din = '0; din_valid = 1'b0; roi = '0; hit_ready = 1'b1;
        repeat (3) cyc();
        chk("rst_out", {hit_valid, hit_pixel, hit_data, hit_evt, event_done, frame_err,
                        err_count, overflow, busy}, 64'd0);
        reset = 1'b0;
        cyc();

        // four hits on the diagonal pixels
        dq = '{30'h1, 30'h2, 30'h3, 30'h4};
        run_frame(16'h8421, 4, 0, 1'b0);
        drain("diag");
        chk_counts("diag", 0, 0);
        chk("diag_busy", 64'(busy), 64'd0);

        // first-word latency with the consumer stalled
        hit_ready = 1'b0; roi = 16'h0001;
        send_word(HEADER, 1'b0);
        din = 30'h5; din_valid = 1'b1; cyc(); din_valid = 1'b0;
        cyc(); chk("lat_k1", 64'(hit_valid), 64'd0);
        cyc(); chk("lat_k2", 64'(hit_valid), 64'd1);
        exp_q.push_back({4'd0, 30'h5, 12'(m_evt)}); m_evt++;
        send_word(TRAILER, 1'b0); exp_done++;
        hit_ready = 1'b1;
        drain("lat");

        // zero data words are consumed but not queued
        dq = '{30'h0, 30'h7};
        run_frame(16'h0003, 2, 0, 1'b1);
        drain("drop");
        chk_counts("drop", 0, 0);

        // header inside DATA restarts the frame
        fill_dq(5, 1'b0);
        run_frame(16'hFFFF, 5, 2, 1'b0);
        fill_dq(16, 1'b0);
        run_frame(16'hFFFF, 16, 0, 1'b0);
        drain("restart");
        chk_counts("restart", 0, 0);

        // bad trailer, then a normal frame
        dq = '{30'h9};
        run_frame(16'h0001, 1, 1, 1'b0);
        repeat (3) cyc();
        chk("badtrl_busy", 64'(busy), 64'd0);
        chk_counts("badtrl", 0, 0);
        fill_dq(3, 1'b1);
        run_frame(16'h0700, 3, 0, 1'b1);
        drain("after_bad");

        // random frames with random gaps and random consumer stalls
        rand_rdy = 1'b1;
        prev_term = 0;
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 7))
                0:       r = 16'h0;
                1:       r = 16'h1 << $urandom_range(0, 15);
                default: r = 16'($urandom);
            endcase
            pc = $countones(r);
            term = (f == 39) ? 0 : (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
            if (term == 2 && pc == 0) term = 0;
            n = (term == 2) ? int'($urandom_range(0, pc - 1)) : pc;
            if (prev_term != 2)
                repeat ($urandom_range(0, 2)) send_word(rnd_word(1'b0), 1'b1);
            fill_dq(n, 1'b1);
            run_frame(r, n, term, 1'b1);
            prev_term = term;
        end
        rand_rdy = 1'b0; hit_ready = 1'b1;
        drain("rand");
        chk_counts("rand", 0, 0);
        chk("rand_ovf", 64'(overflow), 64'd0);

        // timeout inside DATA
        roi = 16'h0001;
        send_word(HEADER, 1'b0);
        m_evt++;
        repeat (TIMEOUT - 10) cyc();
        chk("tmo_busy_before", 64'(busy), 64'd1);
        repeat (20) cyc();
        exp_err++;
        chk("tmo_busy_after", 64'(busy), 64'd0);
        chk_counts("tmo", 0, 0);

        // overflow: 48 hits into 32 entries with the consumer stalled
        hit_ready = 1'b0;
        for (int e = 0; e < 3; e++) begin
            fill_dq(16, 1'b0);
            run_frame(16'hFFFF, 16, 0, 1'b0);
        end
        while (exp_q.size() > 32) void'(exp_q.pop_back());
        repeat (4) cyc();
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_valid", 64'(hit_valid), 64'd1);
        n_pop = 0;
        hit_ready = 1'b1;
        drain("ovf");
        chk("ovf_pops", 64'(n_pop), 64'd32);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // reset in the middle of DATA
        hit_ready = 1'b0; roi = 16'hFFFF;
        send_word(HEADER, 1'b0);
        send_word(30'h11, 1'b0);
        send_word(30'h22, 1'b0);
        reset = 1'b1;
        cyc();
        chk("midrst_out", {hit_valid, hit_pixel, hit_data, hit_evt, event_done, frame_err,
                           err_count, overflow, busy}, 64'd0);
        reset = 1'b0;
        exp_q.delete(); m_evt = 0; exp_done = 0; exp_err = 0;
        repeat (3) cyc();
        bd = done_seen; bf = ferr_seen;
        hit_ready = 1'b1;
        dq = '{30'h5};
        run_frame(16'h0010, 1, 0, 1'b0);
        drain("midrst");
        chk_counts("midrst", bd, bf);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
